// File: rtl/recon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : recon_pkg
// Description : Shared defaults, FSM state type and pixel conversion for the
//               reconstructed-image strip writer.
//               Build option: RECON_CLAMP_EN selects saturating conversion;
//               when undefined the conversion is a raw low-byte truncation.
// Revision    : 1.0 - initial release
// ============================================================================
package recon_pkg;

  localparam int DEF_IMG_W = 256;
  localparam int DEF_IMG_H = 256;
  localparam int DEF_LANES = 8;
  localparam int DEF_PIX_W = 17;

  // Magnitude field width of one sign-magnitude lane
  localparam int MAG_W = DEF_PIX_W - 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Sign-magnitude lane to 8-bit pixel
  function automatic logic [7:0] pix_to_u8(input logic sign, input logic [MAG_W-1:0] mag);
`ifdef RECON_CLAMP_EN
    if (sign) begin
      return 8'd0;
    end else if (|mag[MAG_W-1:8]) begin
      return 8'hFF;
    end else begin
      return mag[7:0];
    end
`else
    // Low byte only, matching the software model's truncation
    return mag[7:0];
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : row_fifo2
// Description : Two-entry row FIFO exposing its head entry and occupancy.
//               Pushes into a full FIFO and pops from an empty one are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module row_fifo2 #(
  parameter int WIDTH = 136
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = push_i && (count_q != 2'd2);
  assign w_pop_ok  = pop_i  && (count_q != 2'd0);

  // Occupancy update; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (!w_push_ok && w_pop_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  // Row storage; contents need no reset since occupancy gates their use
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      slot_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; reset discards all buffered rows
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_q ^ w_push_ok;
      rd_ptr_q <= rd_ptr_q ^ w_pop_ok;
      count_q  <= count_d;
    end
  end

  assign head_o  = slot_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/recon_strip_writer.sv
`default_nettype none
// ============================================================================
// Module      : recon_strip_writer
// Description : Accepts 8-lane reconstructed rows in column-strip scan order,
//               converts each lane to an 8-bit pixel and writes one pixel per
//               cycle to frame memory at raster addresses.
//               Build option: RECON_CLAMP_EN (saturating pixel conversion).
// Revision    : 1.0 - initial release
// ============================================================================
module recon_strip_writer
  import recon_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int LANES  = DEF_LANES,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*PIX_W-1:0] in_data,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int NSTRIP  = IMG_W / LANES;
  localparam int DATA_W  = LANES * PIX_W;
  localparam int LANE_W  = (LANES  > 1) ? $clog2(LANES)  : 1;
  localparam int ROW_W   = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
  localparam int STRIP_W = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;

  localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(LANES - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(IMG_H - 1);
  localparam logic [STRIP_W-1:0] LAST_STRIP = STRIP_W'(NSTRIP - 1);

  state_t              state_q, state_d;
  logic [LANE_W-1:0]   lane_q,  lane_d;
  logic [ROW_W-1:0]    row_q,   row_d;
  logic [STRIP_W-1:0]  strip_q, strip_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                frame_done_q, frame_done_d;

  logic                w_push;
  logic                w_pop;
  logic                w_emit;
  logic [1:0]          w_count;
  logic [1:0]          w_count_next;
  logic [DATA_W-1:0]   w_head;
  logic [PIX_W-1:0]    w_lane;
  logic [ADDR_W-1:0]   w_addr;

  row_fifo2 #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (in_data),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // A lane is emitted on every cycle the FIFO holds a row; the head row is
  // released together with its last lane.
  assign w_push = in_valid && in_ready_q;
  assign w_emit = (w_count != 2'd0);
  assign w_pop  = w_emit && (lane_q == LAST_LANE);

  assign w_lane = w_head[int'(lane_q)*PIX_W +: PIX_W];
  assign w_addr = ADDR_W'(row_q) * ADDR_W'(IMG_W)
                + ADDR_W'(strip_q) * ADDR_W'(LANES)
                + ADDR_W'(lane_q);

  // Occupancy after this edge, used for the registered ready flag
  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop) begin
      w_count_next = w_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - 2'd1;
    end
  end

  // Next-state, address counters and registered write port
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    row_d        = row_q;
    strip_d      = strip_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    frame_done_d = 1'b0;
    in_ready_d   = (w_count_next != 2'd2);

    case (state_q)
      IDLE: begin
        if (w_emit && !(w_pop && (w_count_next == 2'd0))) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (w_pop && (w_count_next == 2'd0)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_emit) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = w_addr;
      mem_wdata_d = pix_to_u8(w_lane[PIX_W-1], MAG_W'(w_lane[PIX_W-2:0]));
      if (lane_q == LAST_LANE) begin
        lane_d       = '0;
        frame_done_d = (row_q == LAST_ROW) && (strip_q == LAST_STRIP);
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          strip_d = (strip_q == LAST_STRIP) ? '0 : strip_q + STRIP_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  // State and output registers; reset abandons any partially written row
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      row_q        <= '0;
      strip_q      <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      row_q        <= row_d;
      strip_q      <= strip_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == WRITE) || (w_count != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_recon_strip_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_recon_strip_writer
// Description : Self-checking bench for recon_strip_writer. Accepted rows are
//               turned into expected raster writes by a reference model and
//               queued; a monitor compares every memory write in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_recon_strip_writer;

  localparam int IMG_W  = 256;
  localparam int IMG_H  = 256;
  localparam int LANES  = 8;
  localparam int PIX_W  = 17;
  localparam int ADDR_W = 16;
  localparam int NSTRIP = IMG_W / LANES;
  localparam int ROWS_PER_FRAME = NSTRIP * IMG_H;
  localparam int DATA_W = LANES * PIX_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              frame_done;
  logic              busy;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   model_rows = 0;
  int   fd_seen = 0;
  time  acc_time = 0;

  recon_strip_writer #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .LANES  (LANES),
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference pixel conversion from the sign/magnitude rules
  function automatic logic [7:0] ref_pix(input int sign, input int mag);
`ifdef RECON_CLAMP_EN
    if (sign != 0) return 8'd0;
    if (mag > 255) return 8'd255;
    return 8'(mag);
`else
    return 8'(mag & 255);
`endif
  endfunction

  // Queue the eight raster writes implied by the next accepted row
  task automatic push_expected(input logic [DATA_W-1:0] d);
    int   n, s, r, a;
    exp_t e;
    n = model_rows % ROWS_PER_FRAME;
    s = n / IMG_H;
    r = n % IMG_H;
    for (int k = 0; k < LANES; k++) begin
      a      = r * IMG_W + s * LANES + k;
      e.addr = ADDR_W'(a);
      e.data = ref_pix(int'(d[k*PIX_W + PIX_W - 1]), int'(d[k*PIX_W +: PIX_W-1]));
      e.fd   = (a == IMG_W * IMG_H - 1);
      exp_q.push_back(e);
    end
    model_rows++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic set_lane(inout logic [DATA_W-1:0] d, input int k, input int sign, input int mag);
    d[k*PIX_W +: PIX_W] = {sign[0], 16'(mag)};
  endtask

  task automatic rand_row(output logic [DATA_W-1:0] d);
    int sel, mag, sign;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      sign = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sel  = int'($urandom_range(0, 2));
      if (sel == 0)      mag = int'($urandom_range(0, 255));
      else if (sel == 1) mag = int'($urandom_range(256, 65535));
      else               mag = int'($urandom_range(0, 300));
      set_lane(d, k, sign, mag);
    end
  endtask

  // Offer one row; returns #1 after the accepting edge
  task automatic send_row(input logic [DATA_W-1:0] d);
    int waitc;
    waitc = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_ready required=ready");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc_time = $time;
      push_expected(d);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Wait for all expected writes to appear, bounded
  task automatic drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    @(negedge clk);
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Apply reset at a falling edge, verify reset values, then release
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_rows = 0;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
  endtask

  // Scoreboard monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected actual addr=%0d data=%0d required=no_write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data || frame_done !== mon_e.fd) begin
          errors++;
          $display("FAIL write_compare actual addr=%0d data=%0d fd=%0d required addr=%0d data=%0d fd=%0d",
                   mem_addr, mem_wdata, frame_done, mon_e.addr, mon_e.data, mon_e.fd);
        end
      end
      if (frame_done) fd_seen++;
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_stray actual=1 required=0");
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    time t1, t3;

    // Reset values and first row timing
    do_reset();
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      set_lane(d, k, 0, (k % 4 == 0) ? 100 : (k % 4 == 1) ? 120 : (k % 4 == 2) ? 130 : 140);
    end
    send_row(d);
    @(posedge clk); #1;
    chk("row0_lane0_we", 32'(mem_we), 32'd1);
    chk("row0_lane0_addr", 32'(mem_addr), 32'd0);
    chk("row0_lane0_data", 32'(mem_wdata), 32'd100);
    repeat (7) @(posedge clk);
    #1;
    chk("row0_lane7_addr", 32'(mem_addr), 32'd7);
    chk("row0_lane7_data", 32'(mem_wdata), 32'd140);
    chk("row0_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    chk("row0_idle_we", 32'(mem_we), 32'd0);
    chk("row0_addr_hold", 32'(mem_addr), 32'd7);
    chk("row0_idle_busy", 32'(busy), 32'd0);

    // Clamp / truncation boundary lanes
    rand_row(d);
    set_lane(d, 0, 1, 5);
    set_lane(d, 1, 0, 300);
    send_row(d);
    @(posedge clk); #1;
`ifdef RECON_CLAMP_EN
    chk("clamp_neg", 32'(mem_wdata), 32'd0);
`else
    chk("trunc_neg", 32'(mem_wdata), 32'd5);
`endif
    @(posedge clk); #1;
`ifdef RECON_CLAMP_EN
    chk("clamp_big", 32'(mem_wdata), 32'd255);
`else
    chk("trunc_big", 32'(mem_wdata), 32'd44);
`endif
    drain();

    // Random rows with random idle gaps
    for (int i = 0; i < 40; i++) begin
      rand_row(d);
      send_row(d);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    drain();

    // Backpressure with three back-to-back offers
    do_reset();
    rand_row(d);
    send_row(d);
    t1 = acc_time;
    rand_row(d);
    send_row(d);
    chk("ready_low_after_2nd", 32'(in_ready), 32'd0);
    chk("busy_with_2_rows", 32'(busy), 32'd1);
    rand_row(d);
    send_row(d);
    t3 = acc_time;
    chk("third_accept_gap", 32'((t3 - t1) / 10), 32'(LANES + 1));
    drain();

    // Reset in the middle of a row, then restart from address 0
    do_reset();
    rand_row(d);
    send_row(d);
    repeat (3) @(posedge clk);
    do_reset();
    rand_row(d);
    send_row(d);
    drain();

    // Full frame plus one row: strip wraps, frame end, restart at 0
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < ROWS_PER_FRAME + 1; i++) begin
      rand_row(d);
      send_row(d);
    end
    drain();
    chk("frame_done_pulses", 32'(fd_seen), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/recon_strip_writer.md
# recon_strip_writer

Write-back end of the DCT/IDCT image path. Accepts 8-lane reconstructed pixel rows from `final_idct_process` in column-strip scan order: strip of 8 columns, rows 0..IMG_H-1, then the next strip. Converts each 17-bit sign-magnitude lane to an 8-bit pixel and writes the pixels one per cycle into a single-port frame memory at raster addresses. This rebuilds the image that the stimulus side reads out strip by strip.

## Interface
Parameters:
- IMG_W, 256, image width in pixels; must be a multiple of LANES
- IMG_H, 256, image height in rows
- LANES, 8, pixels per input row vector
- PIX_W, 17, input lane width; bit PIX_W-1 is the sign, the lower bits are the magnitude
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  row vector present
- in_ready  out  1  a row buffer slot is free
- in_data  in  LANES*PIX_W  lane k at bits [k*PIX_W +: PIX_W]; lane 0 = leftmost column
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  raster address: row*IMG_W + col
- mem_wdata  out  8  pixel value
- frame_done  out  1  one-cycle pulse on the final write of a frame
- busy  out  1  a row is buffered or being written

## Operation
- **Accept rule:** a row is accepted on a cycle where in_valid && in_ready. The accepted row is pushed into a 2-entry row FIFO.
- **States.**
  - IDLE: FIFO empty. Moves to WRITE when the FIFO is non-empty.
  - WRITE: emits lane index 0..LANES-1, one per cycle, from the FIFO head.
  - After lane LANES-1, the head is popped. If the FIFO is still non-empty, the block stays in WRITE with lane index 0; otherwise it returns to IDLE.
- **Address counters:** strip s (0..IMG_W/LANES-1) and row r (0..IMG_H-1).
  - mem_addr = r*IMG_W + s*LANES + lane.
  - After each row, r increments.
  - When r = IMG_H-1 completes, r wraps to 0 and s increments.
  - When s wraps, the frame is complete, both counters return to 0, and the next frame starts at address 0 with no idle cycle required.
- **Pixel conversion (RECON_CLAMP_EN defined):**
  - sign=1 → 0.
  - magnitude > 255 → 255.
  - Otherwise, magnitude[7:0].
- **frame_done:** asserted in the same cycle as the mem_we for the last address, (IMG_H-1)*IMG_W + IMG_W-1.
- **busy:** state == WRITE or FIFO non-empty.
- **Simultaneous push and pop:** when a push and a pop happen on the same cycle, the FIFO count is unchanged.
- **in_ready:** registered; in_ready = (count_next < 2). There is no combinational bypass from pop to ready.
- **Reset mid-operation:** FIFO contents are discarded, counters return to 0, state returns to IDLE, and no write is issued in the reset cycle. A partially written row is not resumed.

## Timing
- **Reset values:** in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, frame_done=0, busy=0. in_ready rises on the first cycle after reset deasserts.
- **Latency:** a row accepted at edge t produces writes on cycles t+1 .. t+LANES, in ascending address order. mem_we, mem_addr and mem_wdata are registered together.
- **Throughput:** 1 row per LANES cycles sustained.
  - With 2 slots, in_ready deasserts only when a source offers rows faster than one per LANES cycles.
  - The source holds in_data stable while in_valid && !in_ready.
- mem_we is low on every cycle with no lane emitted; mem_addr and mem_wdata hold their last values.

## Configuration
- **RECON_CLAMP_EN defined:** saturating conversion as in Operation.
- **RECON_CLAMP_EN undefined:** mem_wdata = magnitude[7:0]. The sign bit and the upper magnitude bits are ignored (raw truncation, for bit-exact comparison against a software model's low byte).

## Structure
- **Package `recon_pkg`:**
  - IMG_W, IMG_H, LANES and PIX_W defaults.
  - State enum {IDLE, WRITE}.
  - Function `pix_to_u8(sign, mag)` implementing both configuration variants.
- **Sub-module `row_fifo2`:** 2-entry, LANES*PIX_W-wide FIFO with push, pop, count and head outputs, and synchronous active-high reset.

## Test plan
- **First row:** after reset, push {100,120,130,140,100,120,130,140} (sign=0). Required: writes at addr 0..7 with those values on cycles t+1..t+8, and frame_done=0.
- **Clamp:** push lanes sign=1 mag=5 and sign=0 mag=300.
  - With RECON_CLAMP_EN: 0 and 255.
  - Without: 5 and 44.
- **Strip wrap:** push 257 rows. Required: row 255 writes addr 65280..65287, and row 256 writes addr 8..15.
- **Frame end:** push 8192 rows. Required: the last write is at addr 65535 with frame_done=1 in that cycle only. The next row then writes addr 0..7.
- **Backpressure:** push rows on 3 consecutive cycles. Required: in_ready=0 after the second accept. The third row is accepted once the first row's lane 7 has been written, and no row is lost or duplicated.
- **Reset mid-row:** assert reset during lane 3 of a row. Required: mem_we=0 from the reset edge, busy=0, and the next accepted row writes addr 0.
